seq_mult: RTL and testbench

- Parametrised, sequential successor to the fixed 4x4 combinational array multiplier.
- Radix-2 shift-add engine with unsigned and signed (two's-complement) modes.
- Uses a valid/ready handshake on both the operand side and the result side.
- Sits between the tile's input-capture logic and the output pins. It is also the intended multiply datapath for the PCPI coprocessor front end.

---
 rtl/seq_mult_pkg.sv | 24 ++
 rtl/seq_mult_ripple_adder.sv | 43 ++++
 rtl/seq_mult.sv | 137 +++++++++++++
 tb/tb_seq_mult.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: state encoding
// and the width helper used to size the step counter.
package seq_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10,
        DONE = 2'b11
    } state_t;

    // Number of bits needed to hold values 0..value-1 (ceil(log2(value))).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_mult_ripple_adder.sv
// Ripple-carry adder built from single-bit full adder cells. The multiplier
// uses it both for the per-step partial-product add and for the final
// two's-complement negation.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

module ripple_adder #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .sum  (sum[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[W];

endmodule

// File: rtl/seq_mult.sv
// Radix-2 sequential shift-add multiplier with unsigned and two's-complement
// modes. Operands are accepted in IDLE, W add/shift steps run on magnitudes,
// one FIX cycle applies the sign, and the product is offered in DONE until
// the consumer takes it.
module seq_mult
    import seq_mult_pkg::*;
#(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           signed_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int CNT_W = clog2(W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

    state_t state;
    state_t state_nxt;

    logic [W-1:0]     mcand;
    logic [W-1:0]     mplier;
    logic [2*W-1:0]   acc;
    logic [CNT_W-1:0] cnt;
    logic             neg;

    logic             accept;
    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;

    logic [W-1:0]     step_addend;
    logic [W-1:0]     step_sum;
    logic             step_carry;

    logic [2*W-1:0]   acc_inv;
    logic [2*W-1:0]   neg_sum;
    logic             neg_carry_unused;

    assign accept = in_valid && in_ready;

    // The most negative operand maps to 2^(W-1), which still fits in W
    // unsigned bits, so the magnitude path never overflows.
    assign a_mag = (signed_mode && a[W-1]) ? (~a + 1'b1) : a;
    assign b_mag = (signed_mode && b[W-1]) ? (~b + 1'b1) : b;

    assign step_addend = mplier[0] ? mcand : '0;

    ripple_adder #(.W(W)) u_step_adder (
        .a    (acc[2*W-1:W]),
        .b    (step_addend),
        .cin  (1'b0),
        .sum  (step_sum),
        .cout (step_carry)
    );

    // Negation as ~acc + 1; the carry out is dropped so that -0 wraps to 0.
    assign acc_inv = ~acc;

    ripple_adder #(.W(2*W)) u_neg_adder (
        .a    (acc_inv),
        .b    ('0),
        .cin  (1'b1),
        .sum  (neg_sum),
        .cout (neg_carry_unused)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept, W steps, one sign-fix cycle, then hold.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept)             state_nxt = RUN;
            RUN:  if (cnt == LAST_STEP)   state_nxt = FIX;
            FIX:                          state_nxt = DONE;
            DONE: if (out_ready)          state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs depend only on the current state.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == FIX);
    end

    // Datapath: operand capture, shift-add steps and the final sign fix.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= a_mag;
                        mplier <= b_mag;
                        neg    <= signed_mode & (a[W-1] ^ b[W-1]);
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    acc    <= {step_carry, step_sum, acc[W-1:1]};
                    mplier <= {acc[0], mplier[W-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                end
                FIX: begin
                    product <= neg ? neg_sum : acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult.sv
// Directed self-checking bench for seq_mult: a W=4 instance driven from a
// vector table plus hand-written backpressure and reset sequences, and a W=8
// instance for the wide signed corner case.
module tb_seq_mult;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sm;
        logic [7:0] expected;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;

    logic       in_valid4, in_ready4, sm4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] product4;

    logic        in_valid8, in_ready8, sm8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    int checks;
    int errors;

    vec_t vectors[10];

    seq_mult #(.W(4)) dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid4),
        .in_ready    (in_ready4),
        .a           (a4),
        .b           (b4),
        .signed_mode (sm4),
        .out_valid   (out_valid4),
        .out_ready   (out_ready4),
        .product     (product4),
        .busy        (busy4)
    );

    seq_mult #(.W(8)) dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid8),
        .in_ready    (in_ready8),
        .a           (a8),
        .b           (b8),
        .signed_mode (sm8),
        .out_valid   (out_valid8),
        .out_ready   (out_ready8),
        .product     (product8),
        .busy        (busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Runs one W=4 multiply with out_ready held high and checks latency,
    // product and the return to IDLE.
    task automatic applyStimulus(input vec_t v);
        int lat;
        bit found;
        @(negedge clk);
        checkOutput({v.name, " in_ready before accept"}, 32'(in_ready4), 32'd1);
        a4 = v.a;
        b4 = v.b;
        sm4 = v.sm;
        out_ready4 = 1'b1;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        checkOutput({v.name, " busy after accept"}, 32'(busy4), 32'd1);
        lat = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid4) found = 1'b1;
        end
        checkOutput({v.name, " latency"}, 32'(lat), 32'd5);
        checkOutput({v.name, " product"}, 32'(product4), 32'(v.expected));
        @(posedge clk);
        #1;
        checkOutput({v.name, " in_ready after done"}, 32'(in_ready4), 32'd1);
        checkOutput({v.name, " out_valid after done"}, 32'(out_valid4), 32'd0);
    endtask

    initial begin
        int lat;
        bit found;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0; out_ready8 = 1'b1;

        vectors[0] = '{4'd3,  4'd5,  1'b0, 8'd15,  "u3x5"};
        vectors[1] = '{4'd15, 4'd15, 1'b0, 8'd225, "u15x15"};
        vectors[2] = '{4'd0,  4'd13, 1'b0, 8'd0,   "u0x13"};
        vectors[3] = '{4'hD,  4'd5,  1'b1, 8'hF1,  "s-3x5"};
        vectors[4] = '{4'h8,  4'h8,  1'b1, 8'h40,  "s-8x-8"};
        vectors[5] = '{4'h8,  4'h7,  1'b1, 8'hC8,  "s-8x7"};
        vectors[6] = '{4'd0,  4'hD,  1'b1, 8'h00,  "s0x-3"};
        vectors[7] = '{4'd7,  4'd7,  1'b1, 8'h31,  "s7x7"};
        vectors[8] = '{4'hD,  4'd5,  1'b0, 8'h41,  "u13x5"};
        vectors[9] = '{4'h8,  4'h7,  1'b0, 8'h38,  "u8x7"};

        // Reset state
        #12;
        checkOutput("reset out_valid4", 32'(out_valid4), 32'd0);
        checkOutput("reset busy4", 32'(busy4), 32'd0);
        checkOutput("reset product4", 32'(product4), 32'd0);
        checkOutput("reset product8", 32'(product8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post-reset in_ready4", 32'(in_ready4), 32'd1);
        checkOutput("post-reset in_ready8", 32'(in_ready8), 32'd1);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vectors[i]);
        end

        // Backpressure: product held, extra operands ignored while in DONE
        @(negedge clk);
        out_ready4 = 1'b0;
        a4 = 4'd6; b4 = 4'd3; sm4 = 1'b0;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid4) found = 1'b1;
        end
        checkOutput("bp latency", 32'(lat), 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid4 = (i % 2 == 0);
            a4 = 4'hF; b4 = 4'hF; sm4 = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("bp product", 32'(product4), 32'h12);
            checkOutput("bp in_ready", 32'(in_ready4), 32'd0);
            checkOutput("bp out_valid", 32'(out_valid4), 32'd1);
        end
        @(negedge clk);
        in_valid4 = 1'b0;
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp release out_valid", 32'(out_valid4), 32'd0);
        checkOutput("bp release in_ready", 32'(in_ready4), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp no stray accept", 32'(busy4), 32'd0);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a4 = 4'd5; b4 = 4'd5; sm4 = 1'b0;
        in_valid4 = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("mid-run busy", 32'(busy4), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("abort out_valid", 32'(out_valid4), 32'd0);
        checkOutput("abort busy", 32'(busy4), 32'd0);
        checkOutput("abort product", 32'(product4), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus('{4'd6, 4'd7, 1'b0, 8'd42, "u6x7 after reset"});

        // W=8 signed corner case
        @(negedge clk);
        checkOutput("w8 in_ready", 32'(in_ready8), 32'd1);
        a8 = 8'h80; b8 = 8'h7F; sm8 = 1'b1;
        in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        lat = 0;
        found = 1'b0;
        while (!found && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid8) found = 1'b1;
        end
        checkOutput("w8 latency", 32'(lat), 32'd9);
        checkOutput("w8 product", 32'(product8), 32'hC080);
        @(posedge clk);
        #1;
        checkOutput("w8 in_ready after done", 32'(in_ready8), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
